// File: rtl/mem_wb_pkg.sv
// rtl/mem_wb_pkg.sv - shared state enum and default widths for the MEM/WB vector register
package mem_wb_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int LANES_DEF = 4;
  localparam int RD_W_DEF  = 5;
  localparam int CNT_W_DEF = 16;

  // Occupancy of the two-entry (head, skid) buffer
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } wb_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// rtl/pipe_skid_buf.sv - two-entry skid buffer with registered ready and synchronous flush
module pipe_skid_buf
  import mem_wb_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  wb_state_e    state_q, state_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] skid_q, skid_d;
  logic         in_fire;
  logic         out_fire;

  // ready depends only on registered occupancy, never on out_ready
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = head_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Next occupancy and entry movement; flush wins over every transition
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            head_d  = in_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            head_d = in_data;
          end else if (in_fire) begin
            skid_d  = in_data;
            state_d = FULL;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            head_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State and entry registers, cleared asynchronously so outputs read zero in reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/mem_wb_vreg.sv
// rtl/mem_wb_vreg.sv - MEM/WB pipeline register with vector lanes, strobe qualification and stall counter
module mem_wb_vreg
  import mem_wb_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int LANES = LANES_DEF,
  parameter int RD_W  = RD_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   mem_valid,
  output logic                   mem_ready,
  input  logic [LANES*XLEN-1:0]  mem_mem_data,
  input  logic [LANES*XLEN-1:0]  mem_alu_result,
  input  logic [RD_W-1:0]        mem_rd,
  input  logic                   mem_mem_to_reg,
  input  logic                   mem_reg_write,
  input  logic                   mem_vreg_write,
  input  logic [LANES-1:0]       mem_lane_mask,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic [LANES*XLEN-1:0]  wb_mem_data,
  output logic [LANES*XLEN-1:0]  wb_alu_result,
  output logic [RD_W-1:0]        wb_rd,
  output logic                   wb_mem_to_reg,
  output logic [LANES-1:0]       wb_lane_mask,
  output logic                   wb_reg_write_en,
  output logic                   wb_vreg_write_en,
  output logic [CNT_W-1:0]       stall_cnt
);

  localparam int PW = 2 * LANES * XLEN + RD_W + LANES + 3;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [PW-1:0]    pay_in;
  logic [PW-1:0]    pay_out;
  logic             head_reg_write;
  logic             head_vreg_write;
  logic             out_fire;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign pay_in = {mem_mem_to_reg, mem_reg_write, mem_vreg_write, mem_lane_mask,
                   mem_rd, mem_alu_result, mem_mem_data};

  pipe_skid_buf #(.W(PW)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (mem_valid),
    .in_ready  (mem_ready),
    .in_data   (pay_in),
    .out_valid (wb_valid),
    .out_ready (wb_ready),
    .out_data  (pay_out)
  );

  assign {wb_mem_to_reg, head_reg_write, head_vreg_write, wb_lane_mask,
          wb_rd, wb_alu_result, wb_mem_data} = pay_out;

  // Write strobes only fire when WB actually consumes the head, and never in a flush cycle
  assign out_fire         = wb_valid & wb_ready;
  assign wb_reg_write_en  = out_fire & head_reg_write & ~flush;
  assign wb_vreg_write_en = out_fire & head_vreg_write & ~flush;

  // Count offered-but-refused cycles, sticking at the top value
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (mem_valid && !mem_ready && !flush && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  // Stall counter register; only reset clears it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/mem_wb_vreg.md
MEM_WB_VREG -- requirements
Module: mem_wb_vreg

Interface
REQ-001 SHALL have parameter XLEN, default 32, scalar lane width in bits.
REQ-002 SHALL have parameter LANES, default 4, number of SIMD lanes (4x32 = one AES state).
REQ-003 SHALL have parameter RD_W, default 5, destination register index width.
REQ-004 SHALL have parameter CNT_W, default 16, stall counter width.
REQ-005 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port: flush  in  1  discard all held entries.
REQ-008 SHALL have port: mem_valid  in  1  MEM stage offers an entry.
REQ-009 SHALL have port: mem_ready  out  1  block accepts an entry this cycle.
REQ-010 SHALL have ports: mem_mem_data, mem_alu_result  in  LANES*XLEN  load data / ALU result, lane 0 in LSBs.
REQ-011 SHALL have ports: mem_rd  in  RD_W; mem_mem_to_reg, mem_reg_write, mem_vreg_write  in  1; mem_lane_mask  in  LANES  per-lane vector write enable.
REQ-012 SHALL have ports: wb_valid  out  1; wb_ready  in  1  WB stage consumes the head entry.
REQ-013 SHALL have ports: wb_mem_data, wb_alu_result  out  LANES*XLEN; wb_rd  out  RD_W; wb_mem_to_reg  out  1; wb_lane_mask  out  LANES.
REQ-014 SHALL have ports: wb_reg_write_en, wb_vreg_write_en  out  1  qualified write strobes.
REQ-015 SHALL have port: stall_cnt  out  CNT_W  saturating count of back-pressure cycles.

Function
REQ-016 SHALL hold at most two entries (head, skid) and track them with state EMPTY, ONE or FULL.
REQ-017 SHALL define in_fire = mem_valid & mem_ready and out_fire = wb_valid & wb_ready.
REQ-018 SHALL drive mem_ready = (state != FULL) from registered state only, with no combinational path from wb_ready.
REQ-019 SHALL transition EMPTY->ONE on in_fire, and otherwise stay in EMPTY.
REQ-020 SHALL, in ONE: on in_fire & out_fire stay ONE with head replaced by the new entry; on in_fire only go FULL with the new entry in skid; on out_fire only go EMPTY.
REQ-021 SHALL, in FULL: on out_fire go ONE with skid moved to head; otherwise hold both entries.
REQ-022 SHALL give latency 1 (entry accepted in cycle N visible on wb_* in cycle N+1) and sustain one entry per cycle when wb_ready stays high.
REQ-023 SHALL assert wb_valid iff state != FULL is false or state == ONE, i.e. iff state != EMPTY; wb_* payload SHALL always reflect the head entry.
REQ-024 SHALL drive wb_reg_write_en = out_fire & head.reg_write and wb_vreg_write_en = out_fire & head.vreg_write.
REQ-025 SHALL, on flush, go EMPTY next cycle, drop any same-cycle in_fire, and force both write strobes low in the flush cycle; flush overrides all transitions.
REQ-026 SHALL increment stall_cnt each cycle with mem_valid & !mem_ready & !flush, saturating at 2^CNT_W-1; flush does not clear it.
REQ-027 SHALL preserve entry order; no entry is ever duplicated or lost except by flush.

Reset
REQ-028 SHALL, on rst assertion and independent of clk, set state EMPTY, wb_valid 0, all wb_* payload outputs 0, stall_cnt 0, and hence mem_ready 1 after release.
REQ-029 SHALL discard held entries on reset mid-operation, and SHALL NOT generate write strobes while rst is high.

Structure
REQ-030 SHALL place the state enum (EMPTY, ONE, FULL) and the default parameter constants in shared package mem_wb_pkg.
REQ-031 SHALL instantiate one generic sub-module, pipe_skid_buf (payload width parameter, valid/ready, flush), with mem_wb_vreg handling payload packing, strobe qualification and stall_cnt.

Verification
REQ-032 Stream: mem_valid=1 for 8 cycles, wb_ready=1, rd=1..8 -> wb_rd 1..8 on consecutive cycles, one cycle later, stall_cnt=0.
REQ-033 Back-pressure: wb_ready=0, push rd=3,4,5 -> mem_ready low after 2 accepts, rd=5 held off, stall_cnt increments; wb_ready=1 -> wb_rd 3,4,5 in order.
REQ-034 Flush in FULL with mem_valid=1 rd=9 -> next cycle wb_valid=0, rd=9 never appears, no write strobe.
REQ-035 Lanes: alu_result=128'h00112233_44556677_8899AABB_CCDDEEFF, lane_mask=4'b0101, vreg_write=1 -> identical data and mask on wb_*, wb_vreg_write_en high only on out_fire.
REQ-036 Async reset asserted mid-cycle in FULL -> wb_valid, stall_cnt and payload outputs 0 immediately; mem_ready=1 after release.
REQ-037 Saturation with CNT_W=4: hold back-pressure 20 cycles -> stall_cnt stops at 15.
